// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART_TX serializer with launch timeout
module uart_tx_arbiter #(
  parameter int numReq = 4,
  parameter int dataWidth = 8,
  parameter int busyTimeout = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [numReq-1:0]             reqValid,
  input  logic [numReq*dataWidth-1:0]   reqData,
  input  logic [numReq-1:0]             reqLast,
  output logic [numReq-1:0]             reqReady,
  output logic [dataWidth-1:0]          txData,
  output logic                          txEn,
  input  logic                          txBusy,
  output logic [$clog2(numReq)-1:0]     grantId,
  output logic                          grantValid,
  output logic                          timeoutErr
);
  localparam int IW = $clog2(numReq);
  localparam int CW = $clog2(busyTimeout + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, win, idx, grant_id_n;
  logic [CW-1:0] cnt, cnt_n;
  logic lock, lock_n, found, tx_en_n, grant_valid_n, timeout_n;
  logic [numReq-1:0] req_ready_n;
  logic [dataWidth-1:0] tx_data_n;
  logic [dataWidth-1:0] bytes [numReq];
  for (genvar i = 0; i < numReq; i++) begin : g_byte
    assign bytes[i] = reqData[i*dataWidth +: dataWidth];
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    lock_n = lock;
    cnt_n = cnt;
    tx_data_n = txData;
    tx_en_n = txEn;
    req_ready_n = '0;
    grant_id_n = grantId;
    grant_valid_n = grantValid;
    timeout_n = 1'b0;
    win = ptr;
    idx = '0;
    found = 1'b0;
    for (int k = numReq - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % numReq);
      if (reqValid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    if (lock) begin
      win = grantId;
      found = reqValid[grantId];
    end
    case (state)
      IDLE: if (!txBusy && found) begin
        state_n = LAUNCH;
        tx_data_n = bytes[win];
        tx_en_n = 1'b1;
        req_ready_n[win] = 1'b1;
        grant_id_n = win;
        grant_valid_n = 1'b1;
        cnt_n = '0;
        lock_n = !reqLast[win];
        ptr_n = reqLast[win] ? IW'((int'(win) + 1) % numReq) : ptr;
      end
      LAUNCH: begin
        cnt_n = cnt + 1'b1;
        if (txBusy) begin
          tx_en_n = 1'b0;
          state_n = DRAIN;
        end else if (cnt == CW'(busyTimeout - 1)) begin
          tx_en_n = 1'b0;
          timeout_n = 1'b1;
          lock_n = 1'b0;
          ptr_n = IW'((int'(grantId) + 1) % numReq);
          grant_valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      DRAIN: if (!txBusy) begin
        state_n = IDLE;
        grant_valid_n = lock;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      lock <= 1'b0;
      cnt <= '0;
      txData <= '0;
      txEn <= 1'b0;
      reqReady <= '0;
      grantId <= '0;
      grantValid <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      lock <= lock_n;
      cnt <= cnt_n;
      txData <= tx_data_n;
      txEn <= tx_en_n;
      reqReady <= req_ready_n;
      grantId <= grant_id_n;
      grantValid <= grant_valid_n;
      timeoutErr <= timeout_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1, txBusy = 1'b0, txEn, grantValid, timeoutErr;
  logic [3:0] reqValid = '0, reqLast = '0, reqReady;
  logic [31:0] reqData = '0;
  logic [7:0] txData, seen;
  logic [1:0] grantId;
  typedef struct {int r; logic [7:0] d; bit l;} item_t;
  item_t pend[$];
  bit paused [4];
  int m_ptr = 0, m_lock = 0, m_lid = 0, m_last = 0, passed = 0, total = 0, wt;
  logic [7:0] exp_seq [4];
  always #5 clk = ~clk;
  uart_tx_arbiter #(.numReq(4), .dataWidth(8), .busyTimeout(16)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
    .reqReady(reqReady), .txData(txData), .txEn(txEn), .txBusy(txBusy),
    .grantId(grantId), .grantValid(grantValid), .timeoutErr(timeoutErr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask
  function automatic int head(input int r);
    foreach (pend[k]) if (pend[k].r == r) return k;
    return -1;
  endfunction
  function automatic int pick(input logic [3:0] v);
    if (m_lock != 0) return v[m_lid] ? m_lid : -1;
    for (int k = 0; k < 4; k++) if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction
  task automatic push(input int r, input logic [7:0] d, input bit l);
    item_t it;
    it.r = r;
    it.d = d;
    it.l = l;
    pend.push_back(it);
  endtask
  task automatic present();
    int h;
    for (int i = 0; i < 4; i++) begin
      h = head(i);
      reqValid[i] = h >= 0 && !paused[i];
      reqData[i*8 +: 8] = h >= 0 ? pend[h].d : 8'h00;
      reqLast[i] = h >= 0 && pend[h].l;
    end
  endtask
  task automatic grab(output int waits, output logic [7:0] data);
    int w, h;
    logic [7:0] d;
    present();
    w = pick(reqValid);
    if (w < 0) w = 0;
    h = head(w);
    d = h >= 0 ? pend[h].d : 8'h00;
    waits = 0;
    while (reqReady == 4'b0 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk("ready_seen", 32'(reqReady != 4'b0), 32'd1);
    chk("reqReady", 32'(reqReady), 32'(1 << w));
    chk("txData", 32'(txData), 32'(d));
    chk("txEn_on", 32'(txEn), 32'd1);
    chk("grantId", 32'(grantId), 32'(w));
    chk("grantValid_on", 32'(grantValid), 32'd1);
    data = txData;
    m_last = w;
    if (h >= 0) begin
      if (pend[h].l) begin
        m_lock = 0;
        m_ptr = (w + 1) % 4;
      end else begin
        m_lock = 1;
        m_lid = w;
      end
      pend.delete(h);
    end
    present();
  endtask
  task automatic finish_byte(input int n, input int frame);
    if (n == 0) begin
      for (int i = 1; i < 16; i++) begin
        @(negedge clk);
        chk("to_txEn_hi", 32'(txEn), 32'd1);
        chk("to_err_lo", 32'(timeoutErr), 32'd0);
      end
      @(negedge clk);
      chk("to_txEn_lo", 32'(txEn), 32'd0);
      chk("to_err_pulse", 32'(timeoutErr), 32'd1);
      chk("to_gv", 32'(grantValid), 32'd0);
      m_lock = 0;
      m_ptr = (m_last + 1) % 4;
      @(negedge clk);
      chk("to_err_once", 32'(timeoutErr), 32'd0);
    end else begin
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        chk("launch_txEn", 32'(txEn), 32'd1);
        chk("ready_once", 32'(reqReady), 32'd0);
      end
      txBusy = 1'b1;
      @(negedge clk);
      chk("txEn_drop", 32'(txEn), 32'd0);
      for (int i = 1; i < frame; i++) begin
        @(negedge clk);
        chk("drain_gv", 32'(grantValid), 32'd1);
        chk("drain_txEn", 32'(txEn), 32'd0);
      end
      txBusy = 1'b0;
      @(negedge clk);
      chk("idle_gv", 32'(grantValid), 32'(m_lock));
      if (m_lock != 0) chk("idle_gid", 32'(grantId), 32'(m_lid));
    end
  endtask
  task automatic serve(input int n, input int frame, output logic [7:0] data);
    int w;
    grab(w, data);
    finish_byte(n, frame);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_txEn", 32'(txEn), 32'd0);
    chk("rst_ready", 32'(reqReady), 32'd0);
    chk("rst_gv", 32'(grantValid), 32'd0);
    chk("rst_err", 32'(timeoutErr), 32'd0);
    chk("rst_txData", 32'(txData), 32'd0);
    chk("rst_gid", 32'(grantId), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(i, 8'(8'hA0 + i), 1'b1);
    push(0, 8'hA4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      serve(2, 3, seen);
      chk("rr_seq", 32'(seen), 32'(8'hA0 + k));
    end
    push(0, 8'h70, 1'b1);
    serve(3, 4, seen);
    chk("single", 32'(seen), 32'h70);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b0);
    push(1, 8'h13, 1'b1);
    push(2, 8'h22, 1'b1);
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h22};
    for (int k = 0; k < 2; k++) begin
      serve(2, 2, seen);
      chk("lock_seq", 32'(seen), 32'(exp_seq[k]));
      paused[1] = 1'b1;
      present();
      repeat (5) begin
        @(negedge clk);
        chk("lock_hold_ready", 32'(reqReady), 32'd0);
        chk("lock_hold_gv", 32'(grantValid), 32'd1);
        chk("lock_hold_gid", 32'(grantId), 32'd1);
      end
      paused[1] = 1'b0;
    end
    for (int k = 2; k < 4; k++) begin
      serve(2, 2, seen);
      chk("lock_seq", 32'(seen), 32'(exp_seq[k]));
    end
    push(1, 8'h55, 1'b0);
    push(1, 8'h56, 1'b1);
    push(2, 8'h66, 1'b1);
    exp_seq = '{8'h55, 8'h66, 8'h56, 8'h00};
    for (int k = 0; k < 3; k++) begin
      serve(k == 0 ? 0 : 2, 2, seen);
      chk("timeout_seq", 32'(seen), 32'(exp_seq[k]));
    end
    txBusy = 1'b1;
    push(2, 8'h77, 1'b1);
    present();
    repeat (5) begin
      @(negedge clk);
      chk("busy_idle_ready", 32'(reqReady), 32'd0);
      chk("busy_idle_txEn", 32'(txEn), 32'd0);
    end
    txBusy = 1'b0;
    grab(wt, seen);
    chk("busy_idle_next_edge", 32'(wt), 32'd1);
    finish_byte(2, 2);
    push(1, 8'h88, 1'b1);
    grab(wt, seen);
    txBusy = 1'b1;
    @(negedge clk);
    chk("pre_rst_gv", 32'(grantValid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_gv", 32'(grantValid), 32'd0);
    chk("async_txEn", 32'(txEn), 32'd0);
    chk("async_ready", 32'(reqReady), 32'd0);
    chk("async_gid", 32'(grantId), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txBusy = 1'b0;
    m_ptr = 0;
    m_lock = 0;
    push(3, 8'h99, 1'b1);
    push(1, 8'h9A, 1'b1);
    serve(2, 2, seen);
    chk("post_rst_first", 32'(seen), 32'h9A);
    serve(1, 1, seen);
    chk("post_rst_second", 32'(seen), 32'h99);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          int len;
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
        end
      end
      while (pend.size() > 0) serve($urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), seen);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
